// File: rtl/sys86_video_timing.sv
// Parametrised raster timing generator: pixel enable, H/V counters, sync/blank decodes, vblank strobe, frame counter.
// Optional screen flip of hpos/vpos is enabled by defining SYS86_TIMING_FLIP_EN.
module sys86_video_timing #(
   parameter int CLK_DIV  = 8,
   parameter int H_TOTAL  = 384,
   parameter int H_ACTIVE = 288,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 32,
   parameter int V_TOTAL  = 264,
   parameter int V_ACTIVE = 224,
   parameter int V_FP     = 16,
   parameter int V_SYNC   = 8,
   parameter int FRAME_W  = 8,
   localparam int HW = $clog2(H_TOTAL),
   localparam int VW = $clog2(V_TOTAL)
) (
   input  logic               clk_48m,
   input  logic               rst,
   input  logic               FLIP,
   output logic               pix_ce,
   output logic               CLK_6M,
   output logic [HW-1:0]      hcnt,
   output logic [VW-1:0]      vcnt,
   output logic [HW-1:0]      hpos,
   output logic [VW-1:0]      vpos,
   output logic               CLK_1H,
   output logic               CLK_2H,
   output logic               CLK_4H,
   output logic               nHSYNC,
   output logic               nVSYNC,
   output logic               nHBLANK,
   output logic               nVBLANK,
   output logic               nHRESET,
   output logic               nVRESET,
   output logic               nCOMPSYNC,
   output logic               BLANKING,
   output logic               vblank_stb,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACTIVE - 1);

   if (H_ACTIVE + H_FP + H_SYNC > H_TOTAL) begin : g_bad_h
      $error("sys86_video_timing: H_ACTIVE+H_FP+H_SYNC exceeds H_TOTAL");
   end
   if (V_ACTIVE + V_FP + V_SYNC > V_TOTAL) begin : g_bad_v
      $error("sys86_video_timing: V_ACTIVE+V_FP+V_SYNC exceeds V_TOTAL");
   end

   logic [DW-1:0] div, div_n;
   logic [HW-1:0] hcnt_n, hpos_n;
   logic [VW-1:0] vcnt_n, vpos_n;
   logic          h_wrap, v_wrap, stb_n;
   logic          h_act, v_act, hs_n, vs_n;
   logic          flip_n;

`ifdef SYS86_TIMING_FLIP_EN
   logic flip_q;
   always_ff @(posedge clk_48m) begin
      if (rst) flip_q <= 1'b0;
      else     flip_q <= flip_n;
   end
   // Flip only latches at the frame boundary so a frame is never half-mirrored.
   assign flip_n = v_wrap ? FLIP : flip_q;
`else
   logic unused_flip;
   assign unused_flip = FLIP;
   assign flip_n      = 1'b0;
`endif

   always_comb begin
      h_wrap = pix_ce && (hcnt == H_LAST);
      v_wrap = h_wrap && (vcnt == V_LAST);
      stb_n  = h_wrap && (vcnt == V_ACT_M1);
      div_n  = (div == DIV_LAST) ? '0 : div + DW'(1);
      hcnt_n = hcnt;
      vcnt_n = vcnt;
      if (pix_ce) hcnt_n = h_wrap ? '0 : hcnt + HW'(1);
      if (h_wrap) vcnt_n = v_wrap ? '0 : vcnt + VW'(1);
      h_act  = int'(hcnt_n) < H_ACTIVE;
      v_act  = int'(vcnt_n) < V_ACTIVE;
      hs_n   = !((int'(hcnt_n) >= H_ACTIVE + H_FP) && (int'(hcnt_n) < H_ACTIVE + H_FP + H_SYNC));
      vs_n   = !((int'(vcnt_n) >= V_ACTIVE + V_FP) && (int'(vcnt_n) < V_ACTIVE + V_FP + V_SYNC));
      hpos_n = '0;
      vpos_n = '0;
      if (h_act && v_act) begin
         hpos_n = flip_n ? HW'(H_ACTIVE - 1) - hcnt_n : hcnt_n;
         vpos_n = flip_n ? VW'(V_ACTIVE - 1) - vcnt_n : vcnt_n;
      end
   end

   // Every decode is registered from the next-state counters so it lines up with hcnt/vcnt.
   always_ff @(posedge clk_48m) begin
      if (rst) begin
         div        <= '0;
         pix_ce     <= 1'b0;
         CLK_6M     <= 1'b0;
         hcnt       <= '0;
         vcnt       <= '0;
         hpos       <= '0;
         vpos       <= '0;
         nHBLANK    <= 1'b1;
         nVBLANK    <= 1'b1;
         nHSYNC     <= 1'b1;
         nVSYNC     <= 1'b1;
         nCOMPSYNC  <= 1'b1;
         BLANKING   <= 1'b0;
         nHRESET    <= 1'b0;
         nVRESET    <= 1'b0;
         vblank_stb <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         div        <= div_n;
         pix_ce     <= (div_n == DIV_LAST);
         CLK_6M     <= (div_n >= DIV_HALF);
         hcnt       <= hcnt_n;
         vcnt       <= vcnt_n;
         hpos       <= hpos_n;
         vpos       <= vpos_n;
         nHBLANK    <= h_act;
         nVBLANK    <= v_act;
         nHSYNC     <= hs_n;
         nVSYNC     <= vs_n;
         nCOMPSYNC  <= hs_n ~^ vs_n;
         BLANKING   <= !(h_act && v_act);
         nHRESET    <= (hcnt_n != '0);
         nVRESET    <= (vcnt_n != '0);
         vblank_stb <= stb_n;
         if (stb_n) frame_cnt <= frame_cnt + FRAME_W'(1);
      end
   end

   assign CLK_1H = hcnt[0];
   assign CLK_2H = hcnt[1];
   assign CLK_4H = hcnt[2];

endmodule

// File: tb/tb_sys86_video_timing.sv
// Directed bench: default geometry (A), alternate line geometry (B), tiny geometry for frame-level checks (C).
module tb_sys86_video_timing;

`ifdef SYS86_TIMING_FLIP_EN
   localparam bit FLIP_ON = 1'b1;
`else
   localparam bit FLIP_ON = 1'b0;
`endif
   localparam int LIM = 10000;

   logic clk = 1'b0;
   logic rst_a = 1'b1, rst_c = 1'b1, flip = 1'b1;
   int   cyc = 0, n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [8:0] a_hcnt, a_vcnt, a_hpos, a_vpos;
   logic [7:0] a_frame;
   logic a_pix, a_clk6, a_1h, a_2h, a_4h, a_nhs, a_nvs, a_nhb, a_nvb, a_nhr, a_nvr, a_ncs, a_blk, a_stb;

   logic [8:0] b_hcnt, b_vcnt, b_hpos, b_vpos;
   logic [7:0] b_frame;
   logic b_pix, b_clk6, b_1h, b_2h, b_4h, b_nhs, b_nvs, b_nhb, b_nvb, b_nhr, b_nvr, b_ncs, b_blk, b_stb;

   logic [3:0] c_hcnt, c_vcnt, c_hpos, c_vpos;
   logic [1:0] c_frame;
   logic c_pix, c_clk6, c_1h, c_2h, c_4h, c_nhs, c_nvs, c_nhb, c_nvb, c_nhr, c_nvr, c_ncs, c_blk, c_stb;

   sys86_video_timing u_a (
      .clk_48m(clk), .rst(rst_a), .FLIP(flip), .pix_ce(a_pix), .CLK_6M(a_clk6),
      .hcnt(a_hcnt), .vcnt(a_vcnt), .hpos(a_hpos), .vpos(a_vpos),
      .CLK_1H(a_1h), .CLK_2H(a_2h), .CLK_4H(a_4h), .nHSYNC(a_nhs), .nVSYNC(a_nvs),
      .nHBLANK(a_nhb), .nVBLANK(a_nvb), .nHRESET(a_nhr), .nVRESET(a_nvr),
      .nCOMPSYNC(a_ncs), .BLANKING(a_blk), .vblank_stb(a_stb), .frame_cnt(a_frame));

   sys86_video_timing #(.CLK_DIV(4), .H_TOTAL(320), .H_ACTIVE(256), .H_FP(16), .H_SYNC(24),
                        .V_TOTAL(262), .V_ACTIVE(240), .V_FP(8), .V_SYNC(4)) u_b (
      .clk_48m(clk), .rst(rst_a), .FLIP(flip), .pix_ce(b_pix), .CLK_6M(b_clk6),
      .hcnt(b_hcnt), .vcnt(b_vcnt), .hpos(b_hpos), .vpos(b_vpos),
      .CLK_1H(b_1h), .CLK_2H(b_2h), .CLK_4H(b_4h), .nHSYNC(b_nhs), .nVSYNC(b_nvs),
      .nHBLANK(b_nhb), .nVBLANK(b_nvb), .nHRESET(b_nhr), .nVRESET(b_nvr),
      .nCOMPSYNC(b_ncs), .BLANKING(b_blk), .vblank_stb(b_stb), .frame_cnt(b_frame));

   sys86_video_timing #(.CLK_DIV(2), .H_TOTAL(16), .H_ACTIVE(10), .H_FP(2), .H_SYNC(2),
                        .V_TOTAL(12), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .FRAME_W(2)) u_c (
      .clk_48m(clk), .rst(rst_c), .FLIP(flip), .pix_ce(c_pix), .CLK_6M(c_clk6),
      .hcnt(c_hcnt), .vcnt(c_vcnt), .hpos(c_hpos), .vpos(c_vpos),
      .CLK_1H(c_1h), .CLK_2H(c_2h), .CLK_4H(c_4h), .nHSYNC(c_nhs), .nVSYNC(c_nvs),
      .nHBLANK(c_nhb), .nVBLANK(c_nvb), .nHRESET(c_nhr), .nVRESET(c_nvr),
      .nCOMPSYNC(c_ncs), .BLANKING(c_blk), .vblank_stb(c_stb), .frame_cnt(c_frame));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Wait for hcnt to move onto h (first leaving it if already there).
   task automatic wait_a(input int h);
      int n = 0;
      while (int'(a_hcnt) == h && n < LIM) begin @(negedge clk); n++; end
      while (int'(a_hcnt) != h && n < LIM) begin @(negedge clk); n++; end
      chk("wait_a_timeout", 32'(n < LIM), 1);
   endtask

   task automatic wait_b(input int h);
      int n = 0;
      while (int'(b_hcnt) == h && n < LIM) begin @(negedge clk); n++; end
      while (int'(b_hcnt) != h && n < LIM) begin @(negedge clk); n++; end
      chk("wait_b_timeout", 32'(n < LIM), 1);
   endtask

   task automatic wait_c(input int h, input int v);
      int n = 0;
      while (int'(c_hcnt) == h && int'(c_vcnt) == v && n < LIM) begin @(negedge clk); n++; end
      while (!(int'(c_hcnt) == h && int'(c_vcnt) == v) && n < LIM) begin @(negedge clk); n++; end
      chk("wait_c_timeout", 32'(n < LIM), 1);
   endtask

   task automatic wait_stb();
      int n = 0;
      @(negedge clk);
      while (c_stb !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
      chk("wait_stb_timeout", 32'(n < LIM), 1);
   endtask

   initial begin
      int t0, f0;
      repeat (3) @(negedge clk);
      // Reset state
      chk("rst_hcnt", 32'(a_hcnt), 0);      chk("rst_vcnt", 32'(a_vcnt), 0);
      chk("rst_hpos", 32'(a_hpos), 0);      chk("rst_vpos", 32'(a_vpos), 0);
      chk("rst_frame", 32'(a_frame), 0);    chk("rst_pix_ce", 32'(a_pix), 0);
      chk("rst_clk6m", 32'(a_clk6), 0);     chk("rst_stb", 32'(a_stb), 0);
      chk("rst_nhblank", 32'(a_nhb), 1);    chk("rst_nvblank", 32'(a_nvb), 1);
      chk("rst_nhsync", 32'(a_nhs), 1);     chk("rst_nvsync", 32'(a_nvs), 1);
      chk("rst_ncompsync", 32'(a_ncs), 1);  chk("rst_blanking", 32'(a_blk), 0);
      chk("rst_nhreset", 32'(a_nhr), 0);    chk("rst_nvreset", 32'(a_nvr), 0);

      // Pixel enable cadence and pixel clock duty after release
      rst_a = 1'b0;
      rst_c = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk("pix_ce_cadence", 32'(a_pix), 32'((k % 8) == 7));
         chk("clk6m_duty", 32'(a_clk6), 32'((k % 8) >= 4));
         if (k == 7) chk("hcnt_before_ce", 32'(a_hcnt), 0);
         if (k == 8) chk("hcnt_after_ce", 32'(a_hcnt), 1);
      end

      // Horizontal decodes, default geometry
      wait_a(287); chk("nhblank_287", 32'(a_nhb), 1); chk("hpos_287", 32'(a_hpos), 287);
      chk("blank_287", 32'(a_blk), 0);
      wait_a(288); chk("nhblank_288", 32'(a_nhb), 0); chk("hpos_288", 32'(a_hpos), 0);
      chk("blank_288", 32'(a_blk), 1);
      wait_a(311); chk("nhsync_311", 32'(a_nhs), 1);
      wait_a(312); chk("nhsync_312", 32'(a_nhs), 0); chk("ncsync_312", 32'(a_ncs), 0);
      wait_a(343); chk("nhsync_343", 32'(a_nhs), 0);
      wait_a(344); chk("nhsync_344", 32'(a_nhs), 1);
      wait_a(383); chk("nhreset_383", 32'(a_nhr), 1); chk("vcnt_383", 32'(a_vcnt), 0);
      wait_a(0);   chk("nhreset_0", 32'(a_nhr), 0);   chk("vcnt_line1", 32'(a_vcnt), 1);
      chk("nvreset_line1", 32'(a_nvr), 1);
      wait_a(1);   chk("nhreset_1", 32'(a_nhr), 1);
      wait_a(2);   chk("clk1h_2", 32'(a_1h), 0); chk("clk2h_2", 32'(a_2h), 1); chk("clk4h_2", 32'(a_4h), 0);
      wait_a(5);   chk("clk1h_5", 32'(a_1h), 1); chk("clk2h_5", 32'(a_2h), 0); chk("clk4h_5", 32'(a_4h), 1);
      t0 = cyc;
      wait_a(5);   chk("line_period_a", 32'(cyc - t0), 3072);
      chk("vcnt_line2", 32'(a_vcnt), 2);

      // Alternate geometry line period
      wait_b(5); t0 = cyc;
      wait_b(5); chk("line_period_b", 32'(cyc - t0), 1280);

      // Vertical sync and composite serration, small geometry
      wait_c(0, 9);   chk("nvsync_l9", 32'(c_nvs), 0); chk("ncs_l9_h0", 32'(c_ncs), 0);
      wait_c(12, 9);  chk("nhsync_c12", 32'(c_nhs), 0); chk("ncs_l9_h12", 32'(c_ncs), 1);
      wait_c(15, 10); chk("nvsync_l10", 32'(c_nvs), 0);
      wait_c(0, 11);  chk("nvsync_l11", 32'(c_nvs), 1); chk("ncs_l11_h0", 32'(c_ncs), 1);
      wait_c(12, 11); chk("ncs_l11_h12", 32'(c_ncs), 0);
      wait_c(15, 7);  chk("nvblank_l7", 32'(c_nvb), 1); chk("stb_l7", 32'(c_stb), 0);

      // vblank strobe position, width, period and frame counter wrap
      wait_stb();
      chk("stb_vcnt", 32'(c_vcnt), 8); chk("stb_hcnt", 32'(c_hcnt), 0); chk("stb_nvblank", 32'(c_nvb), 0);
      t0 = cyc; f0 = int'(c_frame);
      @(negedge clk); chk("stb_width", 32'(c_stb), 0);
      for (int i = 1; i <= 4; i++) begin
         wait_stb();
         if (i == 1) chk("stb_period", 32'(cyc - t0), 384);
         chk("frame_cnt_step", 32'(c_frame), 32'((f0 + i) % 4));
      end

      // One-cycle reset inside vblank, then restart timing
      wait_c(5, 9);
      rst_c = 1'b1;
      @(negedge clk);
      chk("mrst_hcnt", 32'(c_hcnt), 0);   chk("mrst_vcnt", 32'(c_vcnt), 0);
      chk("mrst_nvblank", 32'(c_nvb), 1); chk("mrst_nvsync", 32'(c_nvs), 1);
      chk("mrst_stb", 32'(c_stb), 0);     chk("mrst_frame", 32'(c_frame), 0);
      chk("mrst_pix_ce", 32'(c_pix), 0);  chk("mrst_nvreset", 32'(c_nvr), 0);
      rst_c = 1'b0;
      t0 = cyc;
      wait_c(3, 2);
      chk("resume_time", 32'(cyc - t0), 70);
      chk("resume_hpos", 32'(c_hpos), 3); chk("resume_vpos", 32'(c_vpos), 2);
      chk("resume_frame", 32'(c_frame), 0);

      // Frame wrap (hcnt and vcnt together) and flip
      wait_c(15, 11); chk("prewrap_nvreset", 32'(c_nvr), 1);
      wait_c(0, 0);
      chk("wrap_nvreset", 32'(c_nvr), 0); chk("wrap_nhreset", 32'(c_nhr), 0);
      chk("wrap_hpos", 32'(c_hpos), FLIP_ON ? 9 : 0);
      chk("wrap_vpos", 32'(c_vpos), FLIP_ON ? 7 : 0);
      wait_c(5, 0); chk("l0_nvreset", 32'(c_nvr), 0); chk("l0_nhreset", 32'(c_nhr), 1);
      wait_c(3, 2);
      chk("flip_hpos", 32'(c_hpos), FLIP_ON ? 6 : 3);
      chk("flip_vpos", 32'(c_vpos), FLIP_ON ? 5 : 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sys86_video_timing.md
Name: sys86_video_timing

Overview:
- Parametrised raster timing generator; successor to the fixed System 86 timing subsystem.
- Divides the master clock into a pixel clock-enable and pixel clock.
- Runs horizontal and vertical counters with configurable geometry and produces sync, blank, reset strobes, H-phase clocks, composite sync, active-area coordinates, a vblank strobe and a frame counter.
- Drives the tilegen, sprite, videogen and cpu subsystems and the simulation video outputs.

Parameters:
- CLK_DIV, 8, master clocks per pixel; even, >=2 (49.152 MHz / 8 = 6.144 MHz).
- H_TOTAL, 384, pixels per line.
- H_ACTIVE, 288, visible pixels per line.
- H_FP, 24, pixels from end of active area to start of hsync.
- H_SYNC, 32, hsync width in pixels.
- V_TOTAL, 264, lines per frame.
- V_ACTIVE, 224, visible lines.
- V_FP, 16, lines from end of active area to start of vsync.
- V_SYNC, 8, vsync width in lines.
- FRAME_W, 8, frame counter width.

Ports:
- clk_48m  in  1  master clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- FLIP  in  1  screen flip request (used only with the optional feature).
- pix_ce  out  1  one-clk_48m-cycle pixel enable.
- CLK_6M  out  1  pixel clock level.
- hcnt  out  HW=$clog2(H_TOTAL)  horizontal counter.
- vcnt  out  VW=$clog2(V_TOTAL)  vertical counter.
- hpos  out  HW  active-area x coordinate.
- vpos  out  VW  active-area y coordinate.
- CLK_1H, CLK_2H, CLK_4H  out  1 each  hcnt[0], hcnt[1], hcnt[2].
- nHSYNC, nVSYNC, nHBLANK, nVBLANK, nHRESET, nVRESET, nCOMPSYNC, BLANKING  out  1 each.
- vblank_stb  out  1  start-of-vblank pulse.
- frame_cnt  out  FRAME_W  frame counter.

Interface note: Already decided — one clock, clk_48m; reset rst is synchronous and active-high.

Behaviour:
- div counts 0..CLK_DIV-1 every clk_48m cycle and wraps.
- pix_ce is registered and asserted in the cycle in which div==CLK_DIV-1.
- CLK_6M is registered: 1 when div >= CLK_DIV/2, else 0.
- On a cycle where pix_ce is asserted:
  - hcnt increments; at H_TOTAL-1 it wraps to 0.
  - On the hcnt wrap, vcnt increments; at V_TOTAL-1 it wraps to 0.
- All decoded outputs are registered from the next-state counter values, so they are aligned with hcnt/vcnt with zero relative latency and are glitch-free.
- Decodes:
  - nHBLANK = (hcnt < H_ACTIVE).
  - nVBLANK = (vcnt < V_ACTIVE).
  - BLANKING = ~(nHBLANK & nVBLANK).
  - nHSYNC = 0 when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - nVSYNC = 0 when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
  - nHRESET = 0 when hcnt==0.
  - nVRESET = 0 for the whole of line vcnt==0.
  - nCOMPSYNC = nHSYNC XNOR nVSYNC, giving inverted serration during vsync.
  - hpos = hcnt and vpos = vcnt while inside the active area; both are 0 outside it.
- vblank_stb is high for exactly one clk_48m cycle, coincident with vcnt changing from V_ACTIVE-1 to V_ACTIVE.
- frame_cnt increments on that same cycle and wraps modulo 2^FRAME_W.
- Reset (applies at any time, including mid-line or mid-frame):
  - On the next edge: div, hcnt, vcnt, hpos, vpos and frame_cnt = 0.
  - pix_ce=0, CLK_6M=0, vblank_stb=0.
  - nHBLANK=1, nVBLANK=1, nHSYNC=1, nVSYNC=1, nCOMPSYNC=1, BLANKING=0.
  - nHRESET=0, nVRESET=0.
  - Any in-progress sync pulse is truncated.
- Wrap coincidence: hcnt wrap and vcnt wrap on the same pix_ce give hcnt=0, vcnt=0 in one step; no intermediate state is visible.
- Parameter legality: H_ACTIVE+H_FP+H_SYNC <= H_TOTAL and V_ACTIVE+V_FP+V_SYNC <= V_TOTAL. Violation triggers a simulation-time $error at elaboration.

Optional Feature:
- Macro: SYS86_TIMING_FLIP_EN.
- Defined:
  - FLIP is sampled into flip_q on the pix_ce at which hcnt and vcnt both wrap to 0 (frame boundary only, so there is no tearing).
  - While flip_q=1 and inside the active area: hpos = H_ACTIVE-1-hcnt and vpos = V_ACTIVE-1-vcnt.
  - Reset clears flip_q.
- Undefined: the FLIP port is present but ignored; hpos/vpos are never mirrored.

Test Plan:
1. Release rst at cycle T → pix_ce first high at T+8, then every 8 cycles. CLK_6M has a period of 8 cycles at 50% duty. hcnt=1 after the first pix_ce.
2. Free-run defaults → nHBLANK falls at hcnt=288; nHSYNC low for hcnt 312..343. Line period is 3072 clk_48m cycles. nHRESET is low only at hcnt=0. CLK_2H equals hcnt[1].
3. Free-run a full frame → nVSYNC low for lines 240..247. During those lines nCOMPSYNC = ~nHSYNC. vblank_stb pulses once per 811008 cycles, at vcnt 223→224. frame_cnt counts 0→1→2 and wraps 255→0.
4. Assert rst for one cycle at hcnt=100, vcnt=230 (inside vblank) → next cycle all counters are 0, nVBLANK=1, no vblank_stb, frame_cnt=0, and counting resumes correctly.
5. Hold FLIP=1 with SYS86_TIMING_FLIP_EN defined:
   - Mid-frame, hpos still equals hcnt.
   - After the next frame wrap, at hcnt=0, vcnt=0: hpos=287, vpos=223.
   - Without the macro, hpos=0 and vpos=0 at that point.
6. Non-default geometry, CLK_DIV=4, H_TOTAL=320, H_ACTIVE=256, V_TOTAL=262, V_ACTIVE=240 → line period is 1280 clk_48m cycles and vblank_stb occurs at vcnt 239→240.
